// File: rtl/dpram_drv_pkg.sv
// Shared types and helpers for the dual-port RAM test driver.
// State encoding, fill-pattern function and phase-length helper.
package dpram_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE_ST
  } drv_state_e;

  localparam int unsigned PAT_MAX_W = 64;

  // Words per RAM half; also the length of the WRITE and READ phases.
  function automatic int unsigned half_len(input int unsigned addr_width);
    return 32'd1 << (addr_width - 32'd1);
  endfunction

  // Fill pattern: seed XOR address, evaluated at full width and narrowed by the caller.
  function automatic logic [PAT_MAX_W-1:0] pat(input logic [PAT_MAX_W-1:0] seed,
                                               input logic [PAT_MAX_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/dpram_drv_if.sv
// RAM-side bus of the dual-port RAM test driver: two independent one-cycle ports.
// master = driver, slave = RAM under test.
interface dpram_drv_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0] ADDR_A;
  logic [ADDR_WIDTH-1:0] ADDR_B;
  logic [DATA_WIDTH-1:0] DI_A;
  logic [DATA_WIDTH-1:0] DI_B;
  logic [DATA_WIDTH-1:0] DO_A;
  logic [DATA_WIDTH-1:0] DO_B;
  logic                  WE_A;
  logic                  WE_B;
  logic                  RE_A;
  logic                  RE_B;
  logic                  EN_A;
  logic                  EN_B;

  modport master (
    output ADDR_A, ADDR_B, DI_A, DI_B, WE_A, WE_B, RE_A, RE_B, EN_A, EN_B,
    input  DO_A, DO_B
  );

  modport slave (
    input  ADDR_A, ADDR_B, DI_A, DI_B, WE_A, WE_B, RE_A, RE_B, EN_A, EN_B,
    output DO_A, DO_B
  );

endinterface

// File: rtl/dpram_drv_checker.sv
// Per-port read checker: remembers the issued read address for one cycle and compares DO with the pattern.
// Exposes observed data and expected address only when DPRAM_DRV_ERRLOG_EN is defined.
module dpram_drv_checker
  import dpram_drv_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'('hA5)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] do_data,
  output logic                  mismatch_c
`ifdef DPRAM_DRV_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] exp_addr_c,
  output logic [DATA_WIDTH-1:0] obs_data_c
`endif
);

  logic                  pend;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [DATA_WIDTH-1:0] exp_data_c;

  // Read issued this cycle returns data next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend     <= 1'b0;
      exp_addr <= '0;
    end else begin
      pend     <= issue;
      exp_addr <= issue_addr;
    end
  end

  always_comb begin
    exp_data_c = DATA_WIDTH'(pat(PAT_MAX_W'(SEED), PAT_MAX_W'(exp_addr)));
    mismatch_c = pend && (do_data != exp_data_c);
  end

`ifdef DPRAM_DRV_ERRLOG_EN
  assign exp_addr_c = exp_addr;
  assign obs_data_c = do_data;
`endif

endmodule

// File: rtl/dpram_test_driver.sv
// Fills a true dual-port RAM with a known pattern via both ports, cross-reads it and counts mismatches.
// Define DPRAM_DRV_ERRLOG_EN to capture address/data of the first mismatch of each run.
module dpram_test_driver
  import dpram_drv_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           ERR_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'('hA5)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [ERR_WIDTH-1:0]  ERR_COUNT,
  output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_DATA,
  dpram_drv_if.master           ram
);

  localparam int unsigned   IW       = ADDR_WIDTH - 1;
  localparam int unsigned   H        = half_len(ADDR_WIDTH);
  localparam int unsigned   EW1      = ERR_WIDTH + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(H - 1);

  drv_state_e     state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  nidx_c;
  logic           last_c;
  logic           start_c;
  logic           wr_c;
  logic           rd_c;
  logic           mm_a_c;
  logic           mm_b_c;
  logic [EW1-1:0] err_sum_c;
  logic [ERR_WIDTH-1:0] err_next_c;

  function automatic logic [DATA_WIDTH-1:0] pat_w(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(pat(PAT_MAX_W'(SEED), PAT_MAX_W'(a)));
  endfunction

  // Next-cycle port activity and saturating error sum.
  always_comb begin
    last_c     = (idx == IDX_LAST);
    start_c    = START && ((state == IDLE) || (state == DONE_ST));
    wr_c       = start_c || ((state == WRITE) && !last_c);
    rd_c       = ((state == WRITE) && last_c) || ((state == READ) && !last_c);
    nidx_c     = (((state == WRITE) || (state == READ)) && !last_c) ? idx + IW'(1) : '0;
    err_sum_c  = {1'b0, ERR_COUNT} + EW1'(mm_a_c) + EW1'(mm_b_c);
    err_next_c = err_sum_c[ERR_WIDTH] ? '1 : err_sum_c[ERR_WIDTH-1:0];
  end

  // Port A owns the lower half on write and reads the upper half; port B mirrors it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_COUNT  <= '0;
      ram.EN_A   <= 1'b0;
      ram.WE_A   <= 1'b0;
      ram.RE_A   <= 1'b0;
      ram.ADDR_A <= '0;
      ram.DI_A   <= '0;
      ram.EN_B   <= 1'b0;
      ram.WE_B   <= 1'b0;
      ram.RE_B   <= 1'b0;
      ram.ADDR_B <= '0;
      ram.DI_B   <= '0;
    end else begin
      idx        <= nidx_c;
      ERR_COUNT  <= err_next_c;
      ram.EN_A   <= wr_c || rd_c;
      ram.WE_A   <= wr_c;
      ram.RE_A   <= rd_c;
      ram.ADDR_A <= {rd_c, nidx_c};
      ram.DI_A   <= wr_c ? pat_w({1'b0, nidx_c}) : '0;
      ram.EN_B   <= wr_c || rd_c;
      ram.WE_B   <= wr_c;
      ram.RE_B   <= rd_c;
      ram.ADDR_B <= {wr_c, nidx_c};
      ram.DI_B   <= wr_c ? pat_w({1'b1, nidx_c}) : '0;

      case (state)
        IDLE, DONE_ST: begin
          if (start_c) begin
            state     <= WRITE;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_COUNT <= '0;
          end
        end
        WRITE: begin
          if (last_c) state <= READ;
        end
        READ: begin
          if (last_c) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE_ST;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          PASS  <= (err_next_c == '0);
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DPRAM_DRV_ERRLOG_EN
  logic [ADDR_WIDTH-1:0] exp_a_c;
  logic [ADDR_WIDTH-1:0] exp_b_c;
  logic [DATA_WIDTH-1:0] obs_a_c;
  logic [DATA_WIDTH-1:0] obs_b_c;
  logic                  logged;
`endif

  dpram_drv_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEED      (SEED)
  ) u_chk_a (
    .CLK       (CLK),
    .RST       (RST),
    .issue     (ram.EN_A && ram.RE_A),
    .issue_addr(ram.ADDR_A),
    .do_data   (ram.DO_A),
    .mismatch_c(mm_a_c)
`ifdef DPRAM_DRV_ERRLOG_EN
    ,
    .exp_addr_c(exp_a_c),
    .obs_data_c(obs_a_c)
`endif
  );

  dpram_drv_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEED      (SEED)
  ) u_chk_b (
    .CLK       (CLK),
    .RST       (RST),
    .issue     (ram.EN_B && ram.RE_B),
    .issue_addr(ram.ADDR_B),
    .do_data   (ram.DO_B),
    .mismatch_c(mm_b_c)
`ifdef DPRAM_DRV_ERRLOG_EN
    ,
    .exp_addr_c(exp_b_c),
    .obs_data_c(obs_b_c)
`endif
  );

`ifdef DPRAM_DRV_ERRLOG_EN
  // First mismatch of a run is latched; port A takes priority on a same-cycle tie.
  always_ff @(posedge CLK) begin
    if (RST || start_c) begin
      logged         <= 1'b0;
      FIRST_ERR_ADDR <= '0;
      FIRST_ERR_DATA <= '0;
    end else if (!logged && (mm_a_c || mm_b_c)) begin
      logged         <= 1'b1;
      FIRST_ERR_ADDR <= mm_a_c ? exp_a_c : exp_b_c;
      FIRST_ERR_DATA <= mm_a_c ? obs_a_c : obs_b_c;
    end
  end
`else
  assign FIRST_ERR_ADDR = '0;
  assign FIRST_ERR_DATA = '0;
`endif

endmodule

// File: tb/tb_dpram_test_driver.sv
// Bench for dpram_test_driver: two instances (wide and 3-bit error counter) each on a one-cycle RAM model
// with per-address read corruption masks; results are checked against a reference model.
module tb_dpram_test_driver;

  localparam int unsigned    DW     = 8;
  localparam int unsigned    AW     = 4;
  localparam int unsigned    EW     = 16;
  localparam int unsigned    EW_SAT = 3;
  localparam int unsigned    H      = 8;
  localparam int unsigned    WORDS  = 16;
  localparam logic [DW-1:0]  SEED   = 8'hA5;

  logic CLK = 1'b0;
  logic RST;
  logic START;

  logic              BUSY, DONE, PASS;
  logic [EW-1:0]     ERR_COUNT;
  logic [AW-1:0]     FIRST_ERR_ADDR;
  logic [DW-1:0]     FIRST_ERR_DATA;
  logic              S_BUSY, S_DONE, S_PASS;
  logic [EW_SAT-1:0] S_ERR_COUNT;
  logic [AW-1:0]     S_FIRST_ERR_ADDR;
  logic [DW-1:0]     S_FIRST_ERR_DATA;

  logic [DW-1:0] mem   [WORDS];
  logic [DW-1:0] mem_s [WORDS];
  logic [DW-1:0] mask_a[WORDS];
  logic [DW-1:0] mask_b[WORDS];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dpram_drv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram_if ();
  dpram_drv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram_s ();

  dpram_test_driver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW), .SEED(SEED)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_COUNT(ERR_COUNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .FIRST_ERR_DATA(FIRST_ERR_DATA),
    .ram(ram_if)
  );

  dpram_test_driver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW_SAT), .SEED(SEED)) dut_sat (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(S_BUSY), .DONE(S_DONE), .PASS(S_PASS),
    .ERR_COUNT(S_ERR_COUNT), .FIRST_ERR_ADDR(S_FIRST_ERR_ADDR), .FIRST_ERR_DATA(S_FIRST_ERR_DATA),
    .ram(ram_s)
  );

  // One-cycle RAM models; reads are XORed with the per-address corruption mask.
  always @(posedge CLK) begin
    if (ram_if.EN_A) begin
      if (ram_if.WE_A) mem[ram_if.ADDR_A] <= ram_if.DI_A;
      if (ram_if.RE_A) ram_if.DO_A <= mem[ram_if.ADDR_A] ^ mask_a[ram_if.ADDR_A];
    end
    if (ram_if.EN_B) begin
      if (ram_if.WE_B) mem[ram_if.ADDR_B] <= ram_if.DI_B;
      if (ram_if.RE_B) ram_if.DO_B <= mem[ram_if.ADDR_B] ^ mask_b[ram_if.ADDR_B];
    end
  end

  always @(posedge CLK) begin
    if (ram_s.EN_A) begin
      if (ram_s.WE_A) mem_s[ram_s.ADDR_A] <= ram_s.DI_A;
      if (ram_s.RE_A) ram_s.DO_A <= mem_s[ram_s.ADDR_A] ^ mask_a[ram_s.ADDR_A];
    end
    if (ram_s.EN_B) begin
      if (ram_s.WE_B) mem_s[ram_s.ADDR_B] <= ram_s.DI_B;
      if (ram_s.RE_B) ram_s.DO_B <= mem_s[ram_s.ADDR_B] ^ mask_b[ram_s.ADDR_B];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word k of a correctly filled RAM.
  function automatic logic [DW-1:0] ref_word(input int k);
    logic [DW-1:0] kv;
    kv = DW'(k);
    return SEED ^ kv;
  endfunction

  // Reference: port A reads the upper half, port B the lower half, one word of each per cycle.
  function automatic int ref_mismatches();
    int n = 0;
    for (int i = 0; i < int'(H); i++) begin
      if (mask_a[H + i] != '0) n++;
      if (mask_b[i] != '0) n++;
    end
    return n;
  endfunction

  task automatic clear_masks();
    for (int k = 0; k < int'(WORDS); k++) begin
      mask_a[k] = '0;
      mask_b[k] = '0;
    end
  endtask

  task automatic do_run(output int busy_cycles, output logic [31:0] err_at_start,
                        output logic done_at_start);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    err_at_start  = 32'(ERR_COUNT);
    done_at_start = DONE;
    busy_cycles   = 0;
    while (BUSY && busy_cycles < 200) begin
      busy_cycles++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_results(input string tag);
    int            n;
    int            sat_n;
    int            bad;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    logic          found;
    n     = ref_mismatches();
    sat_n = (n > 7) ? 7 : n;
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_pass"}, 32'(PASS), (n == 0) ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(ERR_COUNT), 32'(n));
    check({tag, "_sat_done"}, 32'(S_DONE), 32'd1);
    check({tag, "_sat_err"}, 32'(S_ERR_COUNT), 32'(sat_n));
    check({tag, "_sat_pass"}, 32'(S_PASS), (n == 0) ? 32'd1 : 32'd0);
    bad = 0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (mem[k] !== ref_word(k)) bad++;
    end
    check({tag, "_mem_bad_words"}, 32'(bad), 32'd0);
    fa    = '0;
    fd    = '0;
    found = 1'b0;
    for (int i = 0; i < int'(H) && !found; i++) begin
      if (mask_a[H + i] != '0) begin
        found = 1'b1;
        fa    = AW'(H + i);
        fd    = ref_word(H + i) ^ mask_a[H + i];
      end else if (mask_b[i] != '0) begin
        found = 1'b1;
        fa    = AW'(i);
        fd    = ref_word(i) ^ mask_b[i];
      end
    end
`ifdef DPRAM_DRV_ERRLOG_EN
    check({tag, "_first_addr"}, 32'(FIRST_ERR_ADDR), 32'(fa));
    check({tag, "_first_data"}, 32'(FIRST_ERR_DATA), 32'(fd));
    check({tag, "_sat_first_addr"}, 32'(S_FIRST_ERR_ADDR), 32'(fa));
`else
    check({tag, "_first_addr"}, 32'(FIRST_ERR_ADDR), 32'd0);
    check({tag, "_first_data"}, 32'(FIRST_ERR_DATA), 32'd0);
`endif
  endtask

  task automatic run_and_check(input string tag);
    int          busy;
    logic [31:0] err0;
    logic        done0;
    do_run(busy, err0, done0);
    check({tag, "_busy_len"}, 32'(busy), 32'd17);
    check({tag, "_err_cleared"}, err0, 32'd0);
    check({tag, "_done_cleared"}, 32'(done0), 32'd0);
    check_results(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    RST   = 1'b1;
    START = 1'b0;
    clear_masks();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_pass", 32'(PASS), 32'd0);
    check("rst_err", 32'(ERR_COUNT), 32'd0);
    check("rst_en", {30'd0, ram_if.EN_A, ram_if.EN_B}, 32'd0);
    check("rst_we_re", {28'd0, ram_if.WE_A, ram_if.WE_B, ram_if.RE_A, ram_if.RE_B}, 32'd0);
    check("rst_addr_di", {8'd0, ram_if.ADDR_A, ram_if.ADDR_B, ram_if.DI_A}, 32'd0);
    check("rst_first", {20'd0, FIRST_ERR_ADDR, FIRST_ERR_DATA}, 32'd0);
    check("rst_sat_busy", 32'(S_BUSY), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Clean run with the known-answer words.
    run_and_check("clean");
    check("clean_mem3", 32'(mem[3]), 32'hA6);
    check("clean_mem11", 32'(mem[11]), 32'hAE);

    // Stuck bit on port A read data.
    for (int k = 0; k < int'(WORDS); k++) mask_a[k] = 8'h01;
    run_and_check("stuck_a0");

    // Both ports fully inverted: saturates the narrow counter.
    for (int k = 0; k < int'(WORDS); k++) begin
      mask_a[k] = 8'hFF;
      mask_b[k] = 8'hFF;
    end
    run_and_check("invert_both");
    clear_masks();

    // Reset in the fourth WRITE cycle aborts the run.
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("abort_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_en", {30'd0, ram_if.EN_A, ram_if.EN_B}, 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("abort_done_idle", 32'(DONE), 32'd0);
    run_and_check("after_abort");

    // START held high: one run, then a restart only out of DONE_ST.
    START = 1'b1;
    @(posedge CLK); #1;
    busy = 0;
    while (BUSY && busy < 200) begin
      busy++;
      @(posedge CLK); #1;
    end
    check("held_busy_len", 32'(busy), 32'd17);
    check("held_done", 32'(DONE), 32'd1);
    @(posedge CLK); #1;
    check("held_restart_busy", 32'(BUSY), 32'd1);
    check("held_restart_done", 32'(DONE), 32'd0);
    START = 1'b0;
    busy = 0;
    while (BUSY && busy < 200) begin
      busy++;
      @(posedge CLK); #1;
    end
    check("held_second_len", 32'(busy), 32'd17);
    check_results("held_second");

    // Single corruption on port B read of address 5.
    clear_masks();
    mask_b[5] = 8'h3C;
    run_and_check("errlog_b5");

    // Randomized corruption patterns.
    for (int r = 0; r < 6; r++) begin
      clear_masks();
      for (int k = 0; k < int'(WORDS); k++) begin
        if ($urandom_range(0, 3) == 0) mask_a[k] = DW'($urandom_range(1, 255));
        if ($urandom_range(0, 3) == 0) mask_b[k] = DW'($urandom_range(1, 255));
      end
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      run_and_check($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
